// File: rtl/lsu_dmem_ctrl.sv
// lsu_dmem_ctrl: load/store initiator for a byte-addressed dmem with registered read data.
// Takes one op at a time from execute and returns exactly one response per op to writeback.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (defined: misaligned half/word ops are rejected;
// undefined: misaligned addresses are issued unchanged and dmem services them natively).
module lsu_dmem_ctrl #(
  parameter int unsigned DMEM_W = 16
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_we,
  input  logic [2:0]  i_req_funct3,
  input  logic [31:0] i_req_addr,
  input  logic [31:0] i_req_wdata,
  input  logic [4:0]  i_req_rd,
  output logic        o_rsp_valid,
  input  logic        i_rsp_ready,
  output logic [31:0] o_rsp_data,
  output logic [4:0]  o_rsp_rd,
  output logic        o_rsp_we,
  output logic        o_rsp_err,
  output logic        o_mem_wren,
  output logic [31:0] o_mem_wdata,
  output logic [31:0] o_mem_addr,
  output logic [3:0]  o_mem_bytemask,
  input  logic [31:0] i_mem_rdata
);

  typedef enum logic [1:0] {IDLE, ISSUE, CAPTURE, RESP} state_t;

  state_t      state, state_nxt;

  logic        req_we;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_we, rsp_err;

  logic        accept;
  logic        f3_bad, high_bad, end_bad, misalign, chk_err;
  logic [1:0]  span;
  logic [DMEM_W:0] last_byte;
  logic [31:0] store_data;
  logic [31:0] load_ext;

  assign accept = i_req_valid && o_req_ready;

  // Validate the incoming request: funct3 legality, address range, optional alignment
  always_comb begin
    if (i_req_we)
      f3_bad = i_req_funct3[2] | (&i_req_funct3[1:0]);
    else
      f3_bad = (&i_req_funct3[1:0]) | (i_req_funct3[2] & i_req_funct3[1]);
    case (i_req_funct3[1:0])
      2'b00:   span = 2'd0;
      2'b01:   span = 2'd1;
      default: span = 2'd3;
    endcase
    high_bad  = (i_req_addr >> DMEM_W) != '0;
    // one extra bit catches an access whose last byte runs past the top of dmem
    last_byte = {1'b0, i_req_addr[DMEM_W-1:0]} + {{(DMEM_W-1){1'b0}}, span};
    end_bad   = last_byte[DMEM_W];
`ifdef LSU_MISALIGN_TRAP_EN
    misalign  = ((i_req_funct3[1:0] == 2'b01) && i_req_addr[0]) ||
                ((i_req_funct3[1:0] == 2'b10) && (i_req_addr[1:0] != 2'b00));
`else
    misalign  = 1'b0;
`endif
    chk_err   = f3_bad | high_bad | end_bad | misalign;
    case (i_req_funct3[1:0])
      2'b00:   store_data = {24'b0, i_req_wdata[7:0]};
      2'b01:   store_data = {16'b0, i_req_wdata[15:0]};
      default: store_data = i_req_wdata;
    endcase
  end

  // Zero/sign-extend captured read data according to the latched load type
  always_comb begin
    case (req_funct3)
      3'b000:  load_ext = {{24{i_mem_rdata[7]}}, i_mem_rdata[7:0]};
      3'b001:  load_ext = {{16{i_mem_rdata[15]}}, i_mem_rdata[15:0]};
      3'b100:  load_ext = {24'b0, i_mem_rdata[7:0]};
      3'b101:  load_ext = {16'b0, i_mem_rdata[15:0]};
      default: load_ext = i_mem_rdata;
    endcase
  end

  // State register
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept) state_nxt = chk_err ? RESP : ISSUE;
      ISSUE:   state_nxt = req_we ? RESP : CAPTURE;
      CAPTURE: state_nxt = RESP;
      RESP:    if (i_rsp_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from state; memory strobes only live in ISSUE
  always_comb begin
    o_req_ready    = (state == IDLE) && i_rst_n;
    o_rsp_valid    = (state == RESP);
    o_mem_wren     = (state == ISSUE) && req_we;
    o_mem_bytemask = '0;
    if (state == ISSUE) begin
      case (req_funct3[1:0])
        2'b00:   o_mem_bytemask = 4'b0001;
        2'b01:   o_mem_bytemask = 4'b0011;
        default: o_mem_bytemask = 4'b1111;
      endcase
    end
  end

  // Request latch, dmem address/data registers and response registers
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      req_we     <= 1'b0;
      req_funct3 <= '0;
      req_rd     <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      rsp_data   <= '0;
      rsp_rd     <= '0;
      rsp_we     <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (accept) begin
        req_we     <= i_req_we;
        req_funct3 <= i_req_funct3;
        req_rd     <= i_req_rd;
        rsp_we     <= i_req_we;
        rsp_rd     <= i_req_rd;
        rsp_data   <= '0;
        rsp_err    <= chk_err;
        // rejected ops leave the dmem address/data registers untouched
        if (!chk_err) begin
          mem_addr <= i_req_addr;
          if (i_req_we) mem_wdata <= store_data;
        end
      end
      if (state == CAPTURE) rsp_data <= load_ext;
    end
  end

  assign o_mem_addr  = mem_addr;
  assign o_mem_wdata = mem_wdata;
  assign o_rsp_data  = rsp_data;
  assign o_rsp_rd    = rsp_rd;
  assign o_rsp_we    = rsp_we;
  assign o_rsp_err   = rsp_err;

endmodule

// File: tb/tb_lsu_dmem_ctrl.sv
// tb_lsu_dmem_ctrl: directed plus randomized ops against a byte-array reference model.
module tb_lsu_dmem_ctrl;
  localparam int unsigned DMEM_W = 16;
  localparam longint MEM_BYTES = 65536;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid, req_ready, req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr, req_wdata;
  logic [4:0]  req_rd;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_data;
  logic [4:0]  rsp_rd;
  logic        rsp_we, rsp_err;
  logic        mem_wren;
  logic [31:0] mem_wdata, mem_addr, mem_rdata;
  logic [3:0]  mem_bytemask;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;
  logic [31:0] last_addr = '0;

  logic [7:0] dmem    [0:65535];
  logic [7:0] ref_mem [0:65535];

  always #5 clk = ~clk;

  lsu_dmem_ctrl #(.DMEM_W(DMEM_W)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_req_valid(req_valid), .o_req_ready(req_ready), .i_req_we(req_we),
    .i_req_funct3(req_funct3), .i_req_addr(req_addr), .i_req_wdata(req_wdata),
    .i_req_rd(req_rd),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready), .o_rsp_data(rsp_data),
    .o_rsp_rd(rsp_rd), .o_rsp_we(rsp_we), .o_rsp_err(rsp_err),
    .o_mem_wren(mem_wren), .o_mem_wdata(mem_wdata), .o_mem_addr(mem_addr),
    .o_mem_bytemask(mem_bytemask), .i_mem_rdata(mem_rdata)
  );

  // Byte-addressed dmem: masked lanes are read/written, unmasked lanes read 0, rdata registered
  always @(posedge clk) begin
    logic [31:0] rd_word;
    logic [15:0] idx;
    rd_word = '0;
    for (int i = 0; i < 4; i++) begin
      if (mem_bytemask[i]) begin
        idx = mem_addr[15:0] + 16'(i);
        rd_word[8*i +: 8] = dmem[idx];
        if (mem_wren) dmem[idx] <= mem_wdata[8*i +: 8];
      end
    end
    mem_rdata <= rd_word;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Reference behaviour: decide outcome from the ISA rules and update the byte-array memory
  task automatic model(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, output logic err, output logic [31:0] data,
                       output int unsigned lat, output logic [3:0] mask);
    longint a;
    int size;
    bit legal, inrange, misal;
    logic [31:0] val;
    a    = longint'(addr);
    size = (f3[1:0] == 2'd0) ? 1 : (f3[1:0] == 2'd1) ? 2 : 4;
    if (we) legal = (f3 <= 3'd2);
    else    legal = (f3 <= 3'd2) || (f3 == 3'd4) || (f3 == 3'd5);
    inrange = (a + size) <= MEM_BYTES;
`ifdef LSU_MISALIGN_TRAP_EN
    misal = (a % size) != 0;
`else
    misal = 1'b0;
`endif
    err  = !legal || !inrange || misal;
    data = '0;
    mask = '0;
    if (err) begin
      lat = 1;
    end else begin
      mask = 4'((1 << size) - 1);
      if (we) begin
        lat = 2;
        for (int i = 0; i < size; i++) ref_mem[int'(a) + i] = wdata[8*i +: 8];
      end else begin
        lat = 3;
        val = '0;
        for (int i = 0; i < size; i++) val = val | (32'(ref_mem[int'(a) + i]) << (8*i));
        if (f3 == 3'd0 && val[7])  val = val | 32'hFFFF_FF00;
        if (f3 == 3'd1 && val[15]) val = val | 32'hFFFF_0000;
        data = val;
      end
    end
  endtask

  task automatic do_op(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [4:0] rd, input int unsigned stall);
    logic        e_err;
    logic [31:0] e_data, lanes;
    int unsigned e_lat, lat, n_mask, n_wren;
    logic [3:0]  e_mask;
    bit          seen;
    model(we, f3, addr, wdata, e_err, e_data, e_lat, e_mask);
    lanes = {{8{e_mask[3]}}, {8{e_mask[2]}}, {8{e_mask[1]}}, {8{e_mask[0]}}};
    @(negedge clk);
    check("req_ready_idle", 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata; req_rd = rd;
    seen = 1'b0; lat = 0; n_mask = 0; n_wren = 0;
    for (int c = 1; c <= 8 && !seen; c++) begin
      @(negedge clk);
      req_valid = 1'b0; req_addr = $urandom; req_wdata = $urandom; req_rd = 5'($urandom);
      if (mem_bytemask != '0) begin
        n_mask++;
        check("issue_mask", 32'(mem_bytemask), 32'(e_mask));
        check("issue_addr", mem_addr, addr);
        check("issue_wren", 32'(mem_wren), 32'(we));
        if (we) check("issue_wdata", mem_wdata & lanes, wdata & lanes);
      end
      if (mem_wren) n_wren++;
      if (rsp_valid) begin seen = 1'b1; lat = c; end
    end
    check("issue_count", n_mask, e_err ? 0 : 1);
    check("wren_count", n_wren, (we && !e_err) ? 1 : 0);
    if (!seen) begin
      check("rsp_timeout", 32'd0, 32'd1);
      return;
    end
    if (!e_err) last_addr = addr;
    check("latency", lat, e_lat);
    check("rsp_data", rsp_data, e_data);
    check("rsp_err", 32'(rsp_err), 32'(e_err));
    check("rsp_rd", 32'(rsp_rd), 32'(rd));
    check("rsp_we", 32'(rsp_we), 32'(we));
    check("mem_addr_hold", mem_addr, last_addr);
    check("req_ready_busy", 32'(req_ready), 32'd0);
    for (int s = 0; s < int'(stall); s++) begin
      @(negedge clk);
      check("stall_valid", 32'(rsp_valid), 32'd1);
      check("stall_data", rsp_data, e_data);
      check("stall_err", 32'(rsp_err), 32'(e_err));
      check("stall_rd", 32'(rsp_rd), 32'(rd));
      check("stall_ready", 32'(req_ready), 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_rsp_valid", 32'(rsp_valid), 32'd0);
    check("post_req_ready", 32'(req_ready), 32'd1);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, 32'(req_ready), 32'd0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd0);
    check({tag, "_rsp_data"}, rsp_data, 32'd0);
    check({tag, "_rsp_misc"}, {25'd0, rsp_rd, rsp_we, rsp_err}, 32'd0);
    check({tag, "_wren"}, 32'(mem_wren), 32'd0);
    check({tag, "_mask"}, 32'(mem_bytemask), 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    int unsigned sel;
    logic [31:0] a;
    rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; req_rd = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // fill the regions the random phase reads from
    for (int i = 0; i < 64; i += 4) do_op(1'b1, 3'd2, 32'(i), $urandom, 5'(i), 0);
    for (int i = 'hFFF0; i < 'h10000; i += 4) do_op(1'b1, 3'd2, 32'(i), $urandom, 5'd3, 0);

    do_op(1'b1, 3'd2, 32'h10, 32'hDEAD_BEEF, 5'd1, 0);
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 5'd2, 0);
    do_op(1'b1, 3'd0, 32'h21, 32'h0000_0080, 5'd3, 0);
    do_op(1'b0, 3'd0, 32'h21, 32'h0, 5'd4, 0);
    do_op(1'b0, 3'd4, 32'h21, 32'h0, 5'd5, 0);
    do_op(1'b1, 3'd1, 32'h22, 32'h1234_8001, 5'd6, 0);
    do_op(1'b0, 3'd1, 32'h22, 32'h0, 5'd7, 0);
    do_op(1'b0, 3'd2, 32'h13, 32'h0, 5'd8, 0);
    do_op(1'b0, 3'd2, 32'hFFFE, 32'h0, 5'd9, 0);
    do_op(1'b0, 3'd0, 32'hFFFF, 32'h0, 5'd10, 0);
    do_op(1'b1, 3'd2, 32'h1_0000, 32'hCAFE_F00D, 5'd11, 0);
    do_op(1'b0, 3'd2, 32'h10, 32'h0, 5'd12, 5);

    // reset while a store sits in ISSUE
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_funct3 = 3'd2; req_addr = 32'h100;
    req_wdata = 32'h5555_AAAA; req_rd = 5'd13;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_issue_wren", 32'(mem_wren), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check_all_zero("rst_mid");
    @(negedge clk);
    rst_n = 1'b1;
    last_addr = '0;
    @(negedge clk);
    check("rst_after_ready", 32'(req_ready), 32'd1);
    check("rst_after_valid", 32'(rsp_valid), 32'd0);
    check("rst_after_wren", 32'(mem_wren), 32'd0);
    do_op(1'b0, 3'd3, 32'h10, 32'h0, 5'd14, 0);

    for (int n = 0; n < 200; n++) begin
      sel = $urandom_range(0, 9);
      if (sel <= 6)      a = 32'($urandom_range(0, 60));
      else if (sel == 7) a = 32'h0000_FFF0 + 32'($urandom_range(0, 15));
      else if (sel == 8) a = 32'h0001_0000 + 32'($urandom_range(0, 3));
      else               a = $urandom | 32'h0002_0000;
      do_op(1'($urandom), 3'($urandom), a, $urandom, 5'($urandom), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
